// File: rtl/serial_word_transmitter_if.sv
// Handshake and serial-side signals of serial_word_transmitter, bundled for port connection.
interface serial_word_transmitter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/serial_word_transmitter.sv
// Parallel-to-serial word transmitter with optional inter-word idle gap.
// Define SERIAL_TX_PREAMBLE_EN to precede every word with a "01" sync preamble.
module serial_word_transmitter #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  serial_word_transmitter_if.slave     bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef SERIAL_TX_PREAMBLE_EN
    ST_PRE,
`endif
    ST_DATA,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
`ifdef SERIAL_TX_PREAMBLE_EN
  logic             pre_q, pre_d;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign bus.in_ready = (state_q == ST_IDLE) ||
                        ((state_q == ST_DATA) && (cnt_q == CNT_LAST) && (GAP == 0));
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    ser_out_d = 1'b1;
    done_d    = 1'b0;
`ifdef SERIAL_TX_PREAMBLE_EN
    pre_d     = pre_q;
`endif
    unique case (state_q)
      ST_IDLE: ;
`ifdef SERIAL_TX_PREAMBLE_EN
      ST_PRE: begin
        if (!pre_q) begin
          pre_d     = 1'b1;
          ser_out_d = 1'b1;
        end else begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          ser_out_d = first_bit(shreg_q);
          shreg_d   = shift_word(shreg_q);
        end
      end
`endif
      ST_DATA: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d     = cnt_q + CW'(1);
          ser_out_d = first_bit(shreg_q);
          shreg_d   = shift_word(shreg_q);
          done_d    = (cnt_q + CW'(1)) == CNT_LAST;
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // An accept overrides the end-of-word transition so back-to-back words leave no bubble.
    if (accept) begin
`ifdef SERIAL_TX_PREAMBLE_EN
      state_d   = ST_PRE;
      pre_d     = 1'b0;
      shreg_d   = bus.in_data;
      ser_out_d = 1'b0;
`else
      state_d   = ST_DATA;
      cnt_d     = '0;
      ser_out_d = first_bit(bus.in_data);
      shreg_d   = shift_word(bus.in_data);
`endif
      done_d    = 1'b0;
    end

    busy_d      = (state_d != ST_IDLE);
    ser_valid_d = (state_d == ST_DATA)
`ifdef SERIAL_TX_PREAMBLE_EN
                  || (state_d == ST_PRE)
`endif
                  ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      ser_out_q   <= 1'b1;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIAL_TX_PREAMBLE_EN
      pre_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SERIAL_TX_PREAMBLE_EN
      pre_q       <= pre_d;
`endif
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_serial_word_transmitter.sv
// Scoreboard bench for serial_word_transmitter: three instances (MSB/LSB first, GAP 0/3).
module tb_serial_word_transmitter;
`ifdef SERIAL_TX_PREAMBLE_EN
  localparam int PRE_LEN = 2;
`else
  localparam int PRE_LEN = 0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_word_transmitter_if #(.WIDTH(8)) bus0 ();
  serial_word_transmitter_if #(.WIDTH(8)) bus1 ();
  serial_word_transmitter_if #(.WIDTH(8)) bus2 ();

  serial_word_transmitter #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  serial_word_transmitter #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  serial_word_transmitter #(.WIDTH(8), .MSB_FIRST(1), .GAP(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic       v_valid [3];
  logic [7:0] v_data  [3];
  logic       so [3], sv [3], dn [3], bz [3], rdy [3];

  assign bus0.in_valid = v_valid[0];
  assign bus1.in_valid = v_valid[1];
  assign bus2.in_valid = v_valid[2];
  assign bus0.in_data  = v_data[0];
  assign bus1.in_data  = v_data[1];
  assign bus2.in_data  = v_data[2];
  assign so  = '{bus0.ser_out,   bus1.ser_out,   bus2.ser_out};
  assign sv  = '{bus0.ser_valid, bus1.ser_valid, bus2.ser_valid};
  assign dn  = '{bus0.done,      bus1.done,      bus2.done};
  assign bz  = '{bus0.busy,      bus1.busy,      bus2.busy};
  assign rdy = '{bus0.in_ready,  bus1.in_ready,  bus2.in_ready};

  int   msbv [3] = '{1, 0, 1};
  int   gapv [3] = '{0, 0, 3};
  exp_t q [3][$];
  int   gap_rem [3] = '{0, 0, 0};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected bit stream is queued at the edge that accepts the word.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        q[d].delete();
        gap_rem[d] = 0;
      end else if (v_valid[d] && rdy[d]) begin
        for (int p = 0; p < PRE_LEN; p++) q[d].push_back('{b: (p == 1), last: 1'b0});
        for (int i = 0; i < 8; i++) begin
          exp_t e;
          e.b    = (msbv[d] != 0) ? v_data[d][7-i] : v_data[d][i];
          e.last = (i == 7);
          q[d].push_back(e);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      logic e_so, e_sv, e_dn, e_bz, e_rdy;
      if (q[d].size() > 0) begin
        exp_t e;
        e     = q[d].pop_front();
        e_so  = e.b;
        e_sv  = 1'b1;
        e_dn  = e.last;
        e_bz  = 1'b1;
        e_rdy = e.last && (gapv[d] == 0);
        if (e.last) gap_rem[d] = gapv[d];
      end else if (gap_rem[d] > 0) begin
        e_so = 1'b1; e_sv = 1'b0; e_dn = 1'b0; e_bz = 1'b1; e_rdy = 1'b0;
        gap_rem[d]--;
      end else begin
        e_so = 1'b1; e_sv = 1'b0; e_dn = 1'b0; e_bz = 1'b0; e_rdy = 1'b1;
      end
      chk($sformatf("d%0d ser_out", d),   so[d],  e_so);
      chk($sformatf("d%0d ser_valid", d), sv[d],  e_sv);
      chk($sformatf("d%0d done", d),      dn[d],  e_dn);
      chk($sformatf("d%0d busy", d),      bz[d],  e_bz);
      chk($sformatf("d%0d in_ready", d),  rdy[d], e_rdy);
    end
  end

  task automatic send(input int d, input logic [7:0] w);
    v_valid[d] = 1'b1;
    v_data[d]  = w;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rdy[d]) begin
        @(posedge clk);
        #2;
        v_valid[d] = 1'b0;
        return;
      end
    end
    chk($sformatf("d%0d accept timeout", d), 32'd0, 32'd1);
    v_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #2;
      if (q[d].size() == 0 && gap_rem[d] == 0) begin
        repeat (2) @(posedge clk);
        #2;
        return;
      end
    end
    chk($sformatf("d%0d idle timeout", d), 32'd0, 32'd1);
  endtask

  initial begin
    v_valid = '{1'b0, 1'b0, 1'b0};
    v_data  = '{8'h00, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;
    chk("post-reset ready", rdy[0], 1'b1);
    chk("post-reset ser_out", so[0], 1'b1);

    send(0, 8'hA5); wait_idle(0);
    send(1, 8'hA5); send(1, 8'h01); wait_idle(1);
    send(0, 8'hF0); send(0, 8'h0F); wait_idle(0);
    send(2, 8'hA5); send(2, 8'h3C); wait_idle(2);
    send(0, 8'h80); wait_idle(0);
    send(1, 8'hFE); wait_idle(1);

    // Abort on the 4th data bit: the reset edge must return outputs to idle with no done.
    send(0, 8'hFF);
    repeat (PRE_LEN + 3) @(posedge clk);
    #2;
    chk("abort on data bit", sv[0], 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    chk("abort ser_valid", sv[0], 1'b0);
    chk("abort done", dn[0], 1'b0);
    repeat (3) @(posedge clk);
    #2;
    send(0, 8'h3C); wait_idle(0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
